// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// fetch_queue_unit : prefetching instruction fetch stage with redirect flush.
// Optional FETCH_PERF_CNT_EN adds stall/flush performance counters. Rev 1.0
// ============================================================================
module fetch_queue_unit #(
    parameter int          ADDR_W   = 64,
    parameter int          INSTR_W  = 32,
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          PC_STEP  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_inc_out,
    input  logic               dec_ready,
    output logic               flushing
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_drop_w = 16;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

    logic [INSTR_W-1:0]  r_q_instr [DEPTH];
    logic [ADDR_W-1:0]   r_q_pc    [DEPTH];
    logic [ADDR_W-1:0]   r_a_pc    [DEPTH];
    logic [c_ptr_w-1:0]  r_q_wr, r_q_rd, r_a_wr, r_a_rd;
    logic [c_cnt_w-1:0]  r_count, r_outstanding;
    logic [c_drop_w-1:0] r_drop;
    logic [ADDR_W-1:0]   r_fetch_pc;

    logic [c_cnt_w:0]    w_inflight;
    logic                w_grant, w_drop_active, w_accept, w_push, w_pop;
    logic [c_drop_w-1:0] w_stale, w_drop_redirect;

    assign w_inflight    = {1'b0, r_count} + {1'b0, r_outstanding};
    // reset gates the request so nothing is issued while held in reset
    assign imem_req      = reset && !redirect && (w_inflight < c_depth);
    assign imem_addr     = r_fetch_pc;
    assign w_grant       = imem_req && imem_gnt;
    assign w_drop_active = (r_drop != '0);
    assign w_accept      = imem_rvalid && !w_drop_active && (r_outstanding != '0);
    assign w_push        = w_accept && !redirect;
    assign w_pop         = instr_valid && dec_ready && !redirect;

    // every response still owed by memory becomes stale; one may land this cycle
    assign w_stale         = r_drop + c_drop_w'(r_outstanding);
    assign w_drop_redirect = w_stale - c_drop_w'(imem_rvalid && (w_stale != '0));

    assign instr_valid = (r_count != '0);
    assign instr_out   = r_q_instr[r_q_rd];
    assign pc_out      = r_q_pc[r_q_rd];
    assign pc_inc_out  = pc_out + ADDR_W'(PC_STEP);
    assign flushing    = w_drop_active;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= ADDR_W'(RESET_PC);
            r_q_wr        <= '0;
            r_q_rd        <= '0;
            r_a_wr        <= '0;
            r_a_rd        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
                r_a_pc[i]    <= '0;
            end
        end else if (redirect) begin
            r_fetch_pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
            r_q_wr        <= '0;
            r_q_rd        <= '0;
            r_a_wr        <= '0;
            r_a_rd        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= w_drop_redirect;
        end else begin
            if (w_grant) begin
                r_fetch_pc     <= r_fetch_pc + ADDR_W'(PC_STEP);
                r_a_pc[r_a_wr] <= r_fetch_pc;
                r_a_wr         <= r_a_wr + 1'b1;
            end
            if (w_accept) begin
                r_a_rd <= r_a_rd + 1'b1;
            end
            if (w_push) begin
                r_q_instr[r_q_wr] <= imem_rdata;
                r_q_pc[r_q_wr]    <= r_a_pc[r_a_rd];
                r_q_wr            <= r_q_wr + 1'b1;
            end
            if (w_pop) begin
                r_q_rd <= r_q_rd + 1'b1;
            end
            r_count       <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            r_outstanding <= r_outstanding + c_cnt_w'(w_grant) - c_cnt_w'(w_accept);
            if (imem_rvalid && w_drop_active) begin
                r_drop <= r_drop - c_drop_w'(1);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (instr_valid && !dec_ready && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// tb_fetch_queue_unit : directed self-checking bench with an in-order memory
// model and a delivery scoreboard.
module tb_fetch_queue_unit;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               redirect = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc = '0;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt = 1'b0;
    logic               imem_rvalid = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  pc_out;
    logic [ADDR_W-1:0]  pc_inc_out;
    logic               dec_ready = 1'b0;
    logic               flushing;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        perf_stall_cnt;
    logic [31:0]        perf_flush_cnt;
`endif

    fetch_queue_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
        .RESET_PC(64'd0), .PC_STEP(4)
    ) dut (
        .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
        .pc_inc_out(pc_inc_out), .dec_ready(dec_ready), .flushing(flushing)
`ifdef FETCH_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int epoch    = 0;
    int lat_min  = 1;
    int lat_max  = 1;
    bit rand_gnt = 1'b0;
    bit rand_rdy = 1'b0;
    bit sb_en    = 1'b0;
    logic [ADDR_W-1:0] exp_pc = '0;
    int delivered = 0;
    int stale_returned = 0;

    logic [ADDR_W-1:0] mq_addr [$];
    int                mq_rdy  [$];
    int                mq_ep   [$];

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    function automatic int stale_pending();
        int n = 0;
        foreach (mq_ep[i]) if (mq_ep[i] != epoch) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic g, rv, pop;
        logic [ADDR_W-1:0]  ga, hpc, hinc;
        logic [INSTR_W-1:0] hins;
        int lat;
        g    = imem_req && imem_gnt;
        ga   = imem_addr;
        rv   = imem_rvalid;
        pop  = instr_valid && dec_ready && !redirect;
        hpc  = pc_out;
        hinc = pc_inc_out;
        hins = instr_out;
        @(posedge clock);
        #1;
        cyc++;
        if (rv && mq_addr.size() > 0) begin
            if (mq_ep[0] != epoch) stale_returned++;
            void'(mq_addr.pop_front());
            void'(mq_rdy.pop_front());
            void'(mq_ep.pop_front());
        end
        if (g) begin
            lat = $urandom_range(lat_max, lat_min);
            mq_addr.push_back(ga);
            mq_rdy.push_back(cyc + lat - 1);
            mq_ep.push_back(epoch);
        end
        if (mq_addr.size() > 0 && mq_rdy[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        if (rand_gnt) imem_gnt = 1'($urandom_range(1, 0));
        if (rand_rdy) dec_ready = 1'($urandom_range(1, 0));
        if (pop && sb_en) begin
            check("deliver_pc", hpc, exp_pc);
            check("deliver_instr", 64'(hins), 64'(mem_word(exp_pc)));
            check("deliver_link", hinc, exp_pc + 64'd4);
            exp_pc = exp_pc + 64'd4;
            delivered++;
        end
        check("inv_count", 64'(dut.r_count <= DEPTH), 64'd1);
        check("inv_inflight", 64'(32'(dut.r_count) + 32'(dut.r_outstanding) <= DEPTH), 64'd1);
    endtask

    task automatic do_redirect(input logic [ADDR_W-1:0] target, output int stale_snap);
        redirect    = 1'b1;
        redirect_pc = target;
        #1;
        check("req_low_in_redirect", 64'(imem_req), 64'd0);
        tick();
        redirect = 1'b0;
        epoch++;
        exp_pc = {target[ADDR_W-1:2], 2'b00};
        stale_snap = stale_pending();
        stale_returned = 0;
        #1;
        check("addr_after_redirect", imem_addr, exp_pc);
        check("valid_after_redirect", 64'(instr_valid), 64'd0);
    endtask

    task automatic wait_flush_done(input string tag, input int snap);
        int n = 0;
        while (flushing && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_flush_timeout"}, 64'(flushing), 64'd0);
        check({tag, "_stale_left"}, 64'(stale_pending()), 64'd0);
        check({tag, "_stale_count"}, 64'(stale_returned), 64'(snap));
    endtask

    task automatic wait_first(input string tag, input logic [ADDR_W-1:0] pc);
        int n = 0;
        while (!instr_valid && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(instr_valid), 64'd1);
        check({tag, "_pc"}, pc_out, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap, n, d0;
        // reset state
        #2;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr_out), 64'd0);
        check("rst_pc", pc_out, 64'd0);
        check("rst_link", pc_inc_out, 64'd4);
        check("rst_flushing", 64'(flushing), 64'd0);

        // release with decode stalled: queue fills with PCs 0..12
        @(posedge clock);
        #1;
        reset = 1'b1; imem_gnt = 1'b1; dec_ready = 1'b0;
        #1;
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", imem_addr, 64'd0);
        repeat (10) tick();
        check("stall_req_low", 64'(imem_req), 64'd0);
        check("stall_valid", 64'(instr_valid), 64'd1);
        check("stall_head_pc", pc_out, 64'd0);
        check("stall_head_instr", 64'(instr_out), 64'(mem_word(64'd0)));
        check("stall_fetch_addr", imem_addr, 64'd16);

        // drain and stream sequentially
        dec_ready = 1'b1; sb_en = 1'b1; exp_pc = 64'd0;
        repeat (16) tick();
        check("stream_delivered", 64'(delivered >= 12), 64'd1);

        // redirect to 0x1003 with 3 requests outstanding
        lat_min = 8; lat_max = 8;
        n = 0;
        while (mq_addr.size() != 3 && n < 40) begin tick(); n++; end
        check("setup_three_outstanding", 64'(mq_addr.size()), 64'd3);
        do_redirect(64'h1003, snap);
        check("redirect1_flushing", 64'(flushing), 64'(snap != 0));
        lat_min = 1; lat_max = 1;
        wait_flush_done("redirect1", snap);
        wait_first("redirect1_first", 64'h1000);

        // redirect while flushing, with one stale response still owed
        lat_min = 6; lat_max = 6;
        n = 0;
        while (mq_addr.size() < 3 && n < 40) begin tick(); n++; end
        do_redirect(64'h1800, snap);
        n = 0;
        while (stale_pending() != 1 && n < 40) begin tick(); n++; end
        check("setup_one_stale", 64'(stale_pending()), 64'd1);
        do_redirect(64'h2000, snap);
        check("redirect2_flushing", 64'(flushing), 64'd1);
        wait_flush_done("redirect2", snap);
        wait_first("redirect2_first", 64'h2000);

        // random grant, latency 1..5 and decode stalls
        lat_min = 1; lat_max = 5; rand_gnt = 1'b1; rand_rdy = 1'b1;
        d0 = delivered;
        repeat (300) tick();
        check("random_progress", 64'(delivered - d0 > 20), 64'd1);

        // sequential wrap at the top of the address space
        rand_gnt = 1'b0; rand_rdy = 1'b0; imem_gnt = 1'b1; dec_ready = 1'b1;
        lat_min = 1; lat_max = 1;
        do_redirect(64'hFFFF_FFFF_FFFF_FFFC, snap);
        check("wrap_req", 64'(imem_req), 64'd1);
        tick();
        check("wrap_addr", imem_addr, 64'd0);
        d0 = delivered;
        repeat (40) tick();
        check("wrap_delivered", 64'(delivered - d0 >= 8), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction fetch stage with a prefetch queue, replacing the single-cycle PC/instruction-memory fetch. Issues in-order requests to a latency-tolerant instruction memory port, buffers returned words with their PCs, and hands them to decode through a valid/ready handshake. A branch or branch-register redirect flushes the queue and discards in-flight responses.

Parameters:
ADDR_W, 64, PC and memory address width
INSTR_W, 32, instruction word width
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, PC value after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
redirect  in  1  taken branch / branch-register redirect this cycle
redirect_pc  in  ADDR_W  redirect target; bits [1:0] forced to 0
imem_req  out  1  request valid
imem_addr  out  ADDR_W  request address
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid; responses strictly in request order
imem_rdata  in  INSTR_W  response instruction word
instr_valid  out  1  queue head valid
instr_out  out  INSTR_W  queue head instruction
pc_out  out  ADDR_W  PC of queue head
pc_inc_out  out  ADDR_W  pc_out + PC_STEP (link value)
dec_ready  in  1  decode accepts head; low = hazard stall
flushing  out  1  stale responses still being discarded

Behaviour:
- Reset (reset low, async): fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0; imem_req=0, instr_valid=0, instr_out=0, pc_out=0, pc_inc_out=0+PC_STEP, flushing=0. First request cycle after reset release.
- Issue: imem_req=1 when redirect=0 and (count + outstanding) < DEPTH; imem_addr=fetch_pc. On imem_req&&imem_gnt: fetch_pc += PC_STEP (wraps modulo 2^ADDR_W), outstanding++. Request stays stable until granted.
- Address tracking: internal FIFO of issued addresses (depth DEPTH) pairs each response with its PC.
- Response: imem_rvalid with drop_cnt=0 -> push {rdata, pc} into queue, outstanding--. With drop_cnt>0 -> discard, drop_cnt--, outstanding unchanged.
- Output: instr_valid = queue not empty; head fields combinational from storage. Pop on instr_valid&&dec_ready. Same-cycle push and pop on full queue permitted. Latency: grant to instr_valid >= 1 cycle after imem_rvalid (registered queue write).
- dec_ready low: head held stable; issue continues until count+outstanding=DEPTH, then imem_req drops.
- Redirect (highest priority): next cycle fetch_pc=redirect_pc&~3, queue emptied, address FIFO cleared, drop_cnt = outstanding including any request granted this cycle, minus any response arriving this cycle that would have been discarded anyway; outstanding becomes 0 for new-epoch accounting; imem_req=0 in the redirect cycle; pop in the same cycle is ignored. flushing = (drop_cnt != 0).
- Redirect while flushing: drop_cnt accumulates new outstanding count; never underflows.
- Overflow impossible by construction; assertion in bench: count <= DEPTH, outstanding+count <= DEPTH.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_stall_cnt (32 bits, cycles with instr_valid&&!dec_ready) and perf_flush_cnt (32 bits, number of redirects), both reset to 0, saturating at all-ones. When undefined, ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, imem_gnt=1, 1-cycle rvalid, dec_ready=1 -> addresses 0,4,8,... in order; instr_out/pc_out pairs match; pc_inc_out = pc_out+4.
- dec_ready=0 for 10 cycles, DEPTH=4 -> queue fills with PCs 0..12, imem_req=0, head stays PC 0; release -> drains 0,4,8,12 in order, no gap loss.
- Redirect to 0x1003 with 3 requests outstanding -> next imem_addr=0x1000, flushing=1 for 3 responses, none enqueued; first instr_valid has pc_out=0x1000.
- Second redirect to 0x2000 while flushing with 1 stale pending -> drop_cnt covers all stale responses; first delivered PC=0x2000.
- imem_gnt random, variable rvalid latency 1..5 -> in-order delivery, no duplicates, never more than DEPTH in flight+queued.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC sequential -> next request address 0x0.
